// File: rtl/noc_switch_allocator_pkg.sv
// Shared types and helpers for the NoC switch allocator (port indices, direction vectors, output FSM states).
// Latency: none; this package holds only types, constants and pure functions.
// Backpressure: not applicable.
package noc_pkg;

    localparam int NPORT = 5;
    localparam int IDXW  = $clog2(NPORT);

    // Bit order matches the one-hot direction produced by the xy router.
    typedef enum logic [IDXW-1:0] {
        EAST  = 3'd0,
        WEST  = 3'd1,
        NORTH = 3'd2,
        SOUTH = 3'd3,
        LOCAL = 3'd4
    } port_e;

    typedef logic [NPORT-1:0] dir_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } out_state_e;

    function automatic logic is_onehot(dir_t d);
        return (d != '0) && ((d & (d - dir_t'(1))) == '0);
    endfunction

    function automatic logic [IDXW-1:0] next_idx(logic [IDXW-1:0] i);
        return (i == IDXW'(NPORT - 1)) ? '0 : i + IDXW'(1);
    endfunction

endpackage

// File: rtl/noc_switch_allocator_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping; one-hot grant plus its index.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides whether the grant is taken.
module rr_arbiter
    import noc_pkg::*;
(
    input  dir_t            req,
    input  logic [IDXW-1:0] ptr,
    output dir_t            gnt,
    output logic [IDXW-1:0] idx
);

    always_comb begin
        int c;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < NPORT; k++) begin
            c = int'(ptr) + k;
            if (c >= NPORT) c = c - NPORT;
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IDXW'(c);
            end
        end
    end

endmodule

// File: rtl/noc_switch_allocator.sv
// Wormhole switch allocator: round-robin per output, locks the winner until its tail flit; ALLOC_FAST_RELEASE_EN re-arbitrates in the release cycle.
// Latency: 1 cycle from eligible request to out_busy; handshakes are combinational through the lock.
// Backpressure: in_ready of an owner follows out_ready of its output; non-owners always see in_ready=0.
module noc_switch_allocator
    import noc_pkg::*;
(
    input  logic                   clk,
    input  logic                   nreset,
    input  logic [NPORT*NPORT-1:0] req_dir,
    input  logic [NPORT-1:0]       in_valid,
    input  logic [NPORT-1:0]       in_last,
    input  logic [NPORT-1:0]       out_ready,
    output logic [NPORT-1:0]       in_ready,
    output logic [NPORT-1:0]       out_valid,
    output logic [NPORT*IDXW-1:0]  out_sel,
    output logic [NPORT-1:0]       out_busy,
    output logic                   req_err
);

    dir_t req_ok;
    dir_t req_bad;
    dir_t owns_any;
    dir_t own_mat [NPORT];
    dir_t rdy_mat [NPORT];

    for (genvar i = 0; i < NPORT; i++) begin : g_in
        dir_t dir;
        assign dir        = req_dir[i*NPORT +: NPORT];
        assign req_ok[i]  = in_valid[i] &  is_onehot(dir);
        assign req_bad[i] = in_valid[i] & ~is_onehot(dir);
    end

    assign req_err = |req_bad;

    // An input holding a lock cannot compete for another output.
    always_comb begin
        owns_any = '0;
        in_ready = '0;
        for (int o = 0; o < NPORT; o++) begin
            owns_any = owns_any | own_mat[o];
            in_ready = in_ready | rdy_mat[o];
        end
    end

    for (genvar o = 0; o < NPORT; o++) begin : g_out
        out_state_e      state_q;
        logic [IDXW-1:0] owner_q;
        logic [IDXW-1:0] ptr_q;
        logic [IDXW-1:0] arb_ptr;
        logic [IDXW-1:0] win;
        dir_t            elig;
        dir_t            gnt;
        logic            busy;
        logic            xfer;
        logic            tail;

        for (genvar i = 0; i < NPORT; i++) begin : g_elig
            assign elig[i] = req_ok[i] & req_dir[i*NPORT + o] & ~owns_any[i];
        end

        assign busy = (state_q == LOCKED);
        assign xfer = busy & in_valid[owner_q] & out_ready[o];
        assign tail = xfer & in_last[owner_q];

`ifdef ALLOC_FAST_RELEASE_EN
        // The releasing owner still counts as an owner, so it is already masked out of elig.
        assign arb_ptr = busy ? next_idx(owner_q) : ptr_q;
`else
        assign arb_ptr = ptr_q;
`endif

        rr_arbiter u_arb (
            .req (elig),
            .ptr (arb_ptr),
            .gnt (gnt),
            .idx (win)
        );

        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) begin
                state_q <= IDLE;
                owner_q <= '0;
                ptr_q   <= '0;
            end else if (!busy) begin
                if (|gnt) begin
                    state_q <= LOCKED;
                    owner_q <= win;
                end
            end else if (tail) begin
                ptr_q <= next_idx(owner_q);
`ifdef ALLOC_FAST_RELEASE_EN
                if (|gnt) owner_q <= win;
                else      state_q <= IDLE;
`else
                state_q <= IDLE;
`endif
            end
        end

        assign own_mat[o]               = busy ? (dir_t'(1) << owner_q) : '0;
        assign rdy_mat[o]               = out_ready[o] ? own_mat[o] : '0;
        assign out_busy[o]              = busy;
        assign out_valid[o]             = busy & in_valid[owner_q];
        assign out_sel[o*IDXW +: IDXW]  = busy ? owner_q : '0;
    end

endmodule

// File: tb/tb_noc_switch_allocator.sv
// Self-checking bench for noc_switch_allocator: constant vector table, directed corner sequences, random traffic vs a reference model.
// Inputs are driven 1 time unit after the rising edge and outputs compared 4 units after it.
module tb_noc_switch_allocator;

    localparam int N = 5;

`ifdef ALLOC_FAST_RELEASE_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic          clk;
    logic          nreset;
    logic [24:0]   req_dir;
    logic [4:0]    in_valid;
    logic [4:0]    in_last;
    logic [4:0]    out_ready;
    logic [4:0]    in_ready;
    logic [4:0]    out_valid;
    logic [14:0]   out_sel;
    logic [4:0]    out_busy;
    logic          req_err;

    int checks   = 0;
    int failures = 0;

    // Reference state: owner per output (-1 when free) and round-robin start index.
    int m_owner [N];
    int m_ptr   [N];

    noc_switch_allocator dut (
        .clk       (clk),
        .nreset    (nreset),
        .req_dir   (req_dir),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sel   (out_sel),
        .out_busy  (out_busy),
        .req_err   (req_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] dir;
        logic [4:0]  v, last, rdy;
        logic [4:0]  e_ir, e_ov, e_busy;
        logic [14:0] e_sel;
        logic        e_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit elig_m(int i, int o);
        logic [4:0] d;
        bit owned;
        d = req_dir[i*N +: N];
        owned = 1'b0;
        for (int k = 0; k < N; k++) if (m_owner[k] == i) owned = 1'b1;
        return in_valid[i] && ($countones(d) == 1) && d[o] && !owned;
    endfunction

    function automatic int pick(int o, int start);
        for (int k = 0; k < N; k++) begin
            int c = (start + k) % N;
            if (elig_m(c, o)) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int o = 0; o < N; o++) begin
            m_owner[o] = -1;
            m_ptr[o]   = 0;
        end
    endtask

    task automatic model_step();
        int nxt_owner [N];
        int nxt_ptr   [N];
        for (int o = 0; o < N; o++) begin
            nxt_owner[o] = m_owner[o];
            nxt_ptr[o]   = m_ptr[o];
            if (m_owner[o] < 0) begin
                nxt_owner[o] = pick(o, m_ptr[o]);
            end else if (in_valid[m_owner[o]] && out_ready[o] && in_last[m_owner[o]]) begin
                nxt_ptr[o]   = (m_owner[o] + 1) % N;
                nxt_owner[o] = FAST ? pick(o, nxt_ptr[o]) : -1;
            end
        end
        for (int o = 0; o < N; o++) begin
            m_owner[o] = nxt_owner[o];
            m_ptr[o]   = nxt_ptr[o];
        end
    endtask

    task automatic check_model(input string tag);
        logic [4:0]  e_ir, e_ov, e_busy;
        logic [14:0] e_sel;
        logic        e_err;
        e_ir = '0; e_ov = '0; e_busy = '0; e_sel = '0; e_err = 1'b0;
        for (int o = 0; o < N; o++) begin
            if (m_owner[o] >= 0) begin
                e_busy[o]       = 1'b1;
                e_sel[o*3 +: 3] = 3'(m_owner[o]);
                e_ov[o]         = in_valid[m_owner[o]];
                if (out_ready[o]) e_ir[m_owner[o]] = 1'b1;
            end
        end
        for (int i = 0; i < N; i++)
            if (in_valid[i] && $countones(req_dir[i*N +: N]) != 1) e_err = 1'b1;
        check({tag, ".in_ready"},  32'(in_ready),  32'(e_ir));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
        check({tag, ".out_sel"},   32'(out_sel),   32'(e_sel));
        check({tag, ".out_busy"},  32'(out_busy),  32'(e_busy));
        check({tag, ".req_err"},   32'(req_err),   32'(e_err));
    endtask

    // Advance one clock; the model sees the same inputs the DUT sampled.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic step_checked(input string tag);
        #3;
        check_model(tag);
        cycle();
    endtask

    vec_t tbl [8];

    initial begin
        int prev;
        int got [$];
        logic [4:0] d;

        tbl[0] = '{25'h20,    5'b00010, 5'b00000, 5'h1f, 5'b00000, 5'b00000, 5'b00000, 15'h0, 1'b0};
        tbl[1] = '{25'h20,    5'b00010, 5'b00000, 5'h1f, 5'b00010, 5'b00001, 5'b00001, 15'h1, 1'b0};
        tbl[2] = '{25'h20,    5'b00010, 5'b00000, 5'h1f, 5'b00010, 5'b00001, 5'b00001, 15'h1, 1'b0};
        tbl[3] = '{25'h20,    5'b00010, 5'b00010, 5'h1f, 5'b00010, 5'b00001, 5'b00001, 15'h1, 1'b0};
        tbl[4] = '{25'h0,     5'b00000, 5'b00000, 5'h1f, 5'b00000, 5'b00000, 5'b00000, 15'h0, 1'b0};
        tbl[5] = '{25'h18000, 5'b01000, 5'b00000, 5'h1f, 5'b00000, 5'b00000, 5'b00000, 15'h0, 1'b1};
        tbl[6] = '{25'h0,     5'b01000, 5'b00000, 5'h1f, 5'b00000, 5'b00000, 5'b00000, 15'h0, 1'b1};
        tbl[7] = '{25'h0,     5'b00000, 5'b00000, 5'h1f, 5'b00000, 5'b00000, 5'b00000, 15'h0, 1'b0};

        nreset = 1'b0; req_dir = '0; in_valid = '0; in_last = '0; out_ready = '0;
        model_reset();
        #3;
        check("reset.in_ready",  32'(in_ready),  32'h0);
        check("reset.out_valid", 32'(out_valid), 32'h0);
        check("reset.out_sel",   32'(out_sel),   32'h0);
        check("reset.out_busy",  32'(out_busy),  32'h0);
        check("reset.req_err",   32'(req_err),   32'h0);
        @(posedge clk); #1;
        nreset = 1'b1;

        // Single 3-flit packet from input 1 to east, then malformed requests from input 3.
        for (int r = 0; r < 8; r++) begin
            req_dir = tbl[r].dir; in_valid = tbl[r].v; in_last = tbl[r].last; out_ready = tbl[r].rdy;
            #3;
            check($sformatf("tbl%0d.in_ready", r),  32'(in_ready),  32'(tbl[r].e_ir));
            check($sformatf("tbl%0d.out_valid", r), 32'(out_valid), 32'(tbl[r].e_ov));
            check($sformatf("tbl%0d.out_sel", r),   32'(out_sel),   32'(tbl[r].e_sel));
            check($sformatf("tbl%0d.out_busy", r),  32'(out_busy),  32'(tbl[r].e_busy));
            check($sformatf("tbl%0d.req_err", r),   32'(req_err),   32'(tbl[r].e_err));
            cycle();
        end

        // Contention: inputs 0, 2, 4 send single-flit packets to the local output.
        req_dir = (25'h1 << 4) | (25'h1 << 14) | (25'h1 << 24);
        in_valid = 5'b10101; in_last = 5'h1f; out_ready = 5'h1f;
        for (int c = 0; c < 10; c++) begin
            #3;
            check_model("cont");
            if (out_busy[4]) got.push_back(int'(out_sel[14:12]));
            prev = m_owner[4];
            cycle();
            if (prev >= 0) in_valid[prev] = 1'b0;
        end
        check("cont.grants", 32'(got.size()), 32'd3);
        for (int k = 0; k < 3; k++)
            if (k < got.size()) check($sformatf("cont.owner%0d", k), 32'(got[k]), 32'(2 * k));

        // Parallel grants: input 0 -> west, input 1 -> east in the same cycle.
        req_dir = 25'h22; in_valid = 5'b00011; in_last = 5'b00011;
        step_checked("par0");
        #3;
        check_model("par1");
        check("par.busy", 32'(out_busy[1:0]), 32'h3);
        check("par.sel0", 32'(out_sel[2:0]),  32'd1);
        check("par.sel1", 32'(out_sel[5:3]),  32'd0);
        cycle();
        in_valid = '0;
        step_checked("par2");

        // Backpressure then bubble on output 2, owned by input 3.
        req_dir = 25'h1 << 17; in_valid = 5'b01000; in_last = '0; out_ready = 5'h1f;
        step_checked("bp_grant");
        step_checked("bp_flit1");
        out_ready[2] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #3;
            check_model("bp_hold");
            check("bp.in_ready", 32'(in_ready[3]), 32'd0);
            check("bp.lock", 32'({out_busy[2], out_sel[8:6]}), 32'hb);
            cycle();
        end
        out_ready[2] = 1'b1; in_valid[3] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #3;
            check_model("bubble");
            check("bubble.out_valid", 32'(out_valid[2]), 32'd0);
            check("bubble.lock", 32'({out_busy[2], out_sel[8:6]}), 32'hb);
            cycle();
        end
        in_valid[3] = 1'b1; in_last[3] = 1'b1;
        #3;
        check_model("bp_tail");
        check("bp.tail_xfer", 32'(out_valid[2] & in_ready[3]), 32'd1);
        cycle();
        in_valid = '0; in_last = '0;
        #3;
        check("bp.released", 32'(out_busy[2]), 32'd0);
        step_checked("bp_idle");

        // Reset mid-packet: move output 3's pointer to 3, then abort a 4-flit packet from input 4.
        req_dir = 25'h1 << 13; in_valid = 5'b00100; in_last = 5'b00100;
        step_checked("rst_a0");
        step_checked("rst_a1");
        in_valid = '0; in_last = '0;
        step_checked("rst_a2");
        req_dir = 25'h1 << 23; in_valid = 5'b10000;
        step_checked("rst_b0");
        step_checked("rst_b1");
        #2;
        nreset = 1'b0;
        #1;
        check("rst.in_ready",  32'(in_ready),  32'h0);
        check("rst.out_valid", 32'(out_valid), 32'h0);
        check("rst.out_sel",   32'(out_sel),   32'h0);
        check("rst.out_busy",  32'(out_busy),  32'h0);
        model_reset();
        @(posedge clk); #1;
        nreset = 1'b1;
        req_dir = (25'h1 << 3) | (25'h1 << 23); in_valid = 5'b10001; in_last = 5'b10001;
        step_checked("rst_c0");
        #3;
        check_model("rst_c1");
        check("rst.regrant", 32'({out_busy[3], out_sel[11:9]}), 32'h8);
        cycle();
        in_valid = '0; in_last = '0;
        step_checked("rst_c2");
        step_checked("rst_c3");

        // Random traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) == 0) d = 5'($urandom);
                else                           d = 5'b00001 << $urandom_range(0, 4);
                req_dir[i*N +: N] = d;
                in_valid[i]  = ($urandom_range(0, 3) != 0);
                in_last[i]   = ($urandom_range(0, 2) == 0);
                out_ready[i] = ($urandom_range(0, 3) != 0);
            end
            step_checked("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
